// File: rtl/uart_tx_arbiter.sv
// rtl/uart_tx_arbiter.sv - round-robin byte arbiter in front of the UART transmit path
`timescale 1ns/1ps
module uart_tx_arbiter #(
  parameter int NUM_REQ     = 4,
  parameter int ACK_TIMEOUT = 15
) (
  input  logic                   i_Clk_12MHz,
  input  logic                   i_Reset_n,
  input  logic [NUM_REQ-1:0]     i_Req_Valid,
  input  logic [8*NUM_REQ-1:0]   i_Req_Data,
  input  logic [NUM_REQ-1:0]     i_Req_Last,
  output logic [NUM_REQ-1:0]     o_Req_Ready,
  output logic [NUM_REQ-1:0]     o_Grant,
  output logic [7:0]             o_Tx_Data,
  output logic                   o_Tx_Wr_En,
  input  logic                   i_Tx_Ready,
  output logic                   o_Busy,
  output logic                   o_Timeout
);

  localparam int               IDX_W       = $clog2(NUM_REQ);
  localparam logic [7:0]       TIMEOUT_CNT = 8'(ACK_TIMEOUT);
  localparam logic [IDX_W:0]   NUM_REQ_W   = (IDX_W+1)'(NUM_REQ);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ACK  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           state, state_next;
  logic             lock, lock_next;
  logic [IDX_W-1:0] lock_idx, lock_idx_next;
  logic [IDX_W-1:0] r_last, r_last_next;
  logic [IDX_W-1:0] owner, owner_next;
  logic [7:0]       cnt, cnt_next, cnt_inc;
  logic [7:0]       tx_data_next;
  logic             wr_en_next;
  logic             timeout_next;
  logic             busy_next;

  logic [IDX_W-1:0] cand;
  logic [IDX_W-1:0] scan_idx;
  logic [IDX_W:0]   scan_sum;
  logic             has_cand;
  logic [7:0]       cand_data;
  logic             cand_last;
  logic             accept;

  // A held lock pins the candidate; otherwise the lowest offset after r_last wins.
  always_comb begin
    cand     = lock_idx;
    has_cand = lock;
    scan_sum = '0;
    scan_idx = '0;
    if (!lock) begin
      for (int i = NUM_REQ; i >= 1; i--) begin
        scan_sum = {1'b0, r_last} + (IDX_W+1)'(i);
        if (scan_sum >= NUM_REQ_W) begin
          scan_sum = scan_sum - NUM_REQ_W;
        end
        scan_idx = scan_sum[IDX_W-1:0];
        if (i_Req_Valid[scan_idx]) begin
          cand     = scan_idx;
          has_cand = 1'b1;
        end
      end
    end
  end

  always_comb begin
    cand_data = 8'h00;
    cand_last = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (cand == IDX_W'(k)) begin
        cand_data = i_Req_Data[8*k +: 8];
        cand_last = i_Req_Last[k];
      end
    end
  end

  always_comb begin
    o_Grant     = '0;
    o_Req_Ready = '0;
    if (state == S_IDLE) begin
      if (has_cand) begin
        o_Grant[cand]     = 1'b1;
        o_Req_Ready[cand] = i_Req_Valid[cand] & i_Tx_Ready;
      end
    end else begin
      o_Grant[owner] = 1'b1;
    end
  end

  assign accept  = |o_Req_Ready;
  assign cnt_inc = (cnt == 8'hFF) ? cnt : cnt + 8'd1;

  always_comb begin
    state_next    = state;
    lock_next     = lock;
    lock_idx_next = lock_idx;
    r_last_next   = r_last;
    owner_next    = owner;
    cnt_next      = cnt;
    tx_data_next  = o_Tx_Data;
    wr_en_next    = 1'b0;
    timeout_next  = 1'b0;
    case (state)
      S_IDLE: begin
        if (accept) begin
          tx_data_next = cand_data;
          wr_en_next   = 1'b1;
          cnt_next     = 8'd0;
          owner_next   = cand;
          state_next   = S_ACK;
          if (cand_last) begin
            lock_next   = 1'b0;
            r_last_next = cand;
          end else begin
            lock_next     = 1'b1;
            lock_idx_next = cand;
          end
        end
      end
      S_ACK: begin
        cnt_next = cnt_inc;
        if (!i_Tx_Ready) begin
          state_next = S_DONE;
        end else if (cnt_inc == TIMEOUT_CNT) begin
          // Transceiver never went busy: drop the byte, keep any message lock.
          timeout_next = 1'b1;
          state_next   = S_IDLE;
        end
      end
      S_DONE: begin
        if (i_Tx_Ready) begin
          state_next = S_IDLE;
        end
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase
    busy_next = (state_next != S_IDLE) || lock_next;
  end

  always_ff @(posedge i_Clk_12MHz or negedge i_Reset_n) begin
    if (!i_Reset_n) begin
      state      <= S_IDLE;
      lock       <= 1'b0;
      lock_idx   <= '0;
      r_last     <= IDX_W'(NUM_REQ-1);
      owner      <= '0;
      cnt        <= 8'd0;
      o_Tx_Data  <= 8'h00;
      o_Tx_Wr_En <= 1'b0;
      o_Timeout  <= 1'b0;
      o_Busy     <= 1'b0;
    end else begin
      state      <= state_next;
      lock       <= lock_next;
      lock_idx   <= lock_idx_next;
      r_last     <= r_last_next;
      owner      <= owner_next;
      cnt        <= cnt_next;
      o_Tx_Data  <= tx_data_next;
      o_Tx_Wr_En <= wr_en_next;
      o_Timeout  <= timeout_next;
      o_Busy     <= busy_next;
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb/tb_uart_tx_arbiter.sv - directed self-checking bench for uart_tx_arbiter
`timescale 1ns/1ps
module tb_uart_tx_arbiter;

  localparam int NUM_REQ     = 4;
  localparam int ACK_TIMEOUT = 15;

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic [NUM_REQ-1:0]   req_valid;
  logic [8*NUM_REQ-1:0] req_data;
  logic [NUM_REQ-1:0]   req_last;
  logic [NUM_REQ-1:0]   req_ready;
  logic [NUM_REQ-1:0]   grant;
  logic [7:0]           tx_data;
  logic                 tx_wr_en;
  logic                 tx_ready;
  logic                 busy;
  logic                 timeout;

  uart_tx_arbiter #(.NUM_REQ(NUM_REQ), .ACK_TIMEOUT(ACK_TIMEOUT)) dut (
    .i_Clk_12MHz (clk),
    .i_Reset_n   (rst_n),
    .i_Req_Valid (req_valid),
    .i_Req_Data  (req_data),
    .i_Req_Last  (req_last),
    .o_Req_Ready (req_ready),
    .o_Grant     (grant),
    .o_Tx_Data   (tx_data),
    .o_Tx_Wr_En  (tx_wr_en),
    .i_Tx_Ready  (tx_ready),
    .o_Busy      (busy),
    .o_Timeout   (timeout)
  );

  always #5 clk = ~clk;

  int vec_cnt = 0;
  int err_cnt = 0;
  int cyc = 0;

  // Per-requester byte queues: {last, data}
  logic [8:0]         rq_mem [NUM_REQ][8];
  int                 rq_head [NUM_REQ];
  int                 rq_tail [NUM_REQ];
  logic [NUM_REQ-1:0] hs;

  logic [7:0]         sent [64];
  logic [NUM_REQ-1:0] sent_grant [64];
  int                 n_sent = 0;
  int                 wr_cyc = 0;
  int                 n_timeout = 0;
  int                 to_cyc = 0;

  // Transceiver model: 0 = drop ready 2 cycles after write for 20 cycles, 1 = stuck idle, 2 = manual
  int   mode = 0;
  int   pend = 0;
  int   low_left = 0;
  logic man_ready = 1'b1;
  logic lock_mon = 1'b0;

  int base;
  int tbase;
  int w;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vec_cnt++;
    if (obs !== exp) begin
      err_cnt++;
      $display("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push(input int k, input logic last, input logic [7:0] data);
    rq_mem[k][rq_tail[k]] = {last, data};
    rq_tail[k]++;
  endtask

  function automatic bit q_empty();
    bit e = 1'b1;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (rq_head[k] < rq_tail[k]) e = 1'b0;
    end
    return e;
  endfunction

  task automatic drive_req();
    for (int k = 0; k < NUM_REQ; k++) begin
      if (rq_head[k] < rq_tail[k]) begin
        req_valid[k]        = 1'b1;
        req_data[8*k +: 8]  = rq_mem[k][rq_head[k]][7:0];
        req_last[k]         = rq_mem[k][rq_head[k]][8];
      end else begin
        req_valid[k]        = 1'b0;
        req_data[8*k +: 8]  = 8'h00;
        req_last[k]         = 1'b0;
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (hs[k] && rq_head[k] < rq_tail[k]) begin
        if (k == 2) lock_mon = ~rq_mem[k][rq_head[k]][8];
        rq_head[k]++;
      end
    end
    if (tx_wr_en === 1'b1) begin
      if (n_sent < 64) begin
        sent[n_sent]       = tx_data;
        sent_grant[n_sent] = grant;
      end
      n_sent++;
      wr_cyc = cyc;
    end
    if (timeout === 1'b1) begin
      n_timeout++;
      to_cyc = cyc;
    end
    if (lock_mon) begin
      check("lock_grant", grant, 4'b0100);
      check("lock_busy", busy, 1);
    end
    if (mode == 0) begin
      if (pend > 0) begin
        pend--;
        if (pend == 0) begin
          tx_ready = 1'b0;
          low_left = 20;
        end
      end else if (low_left > 0) begin
        low_left--;
        if (low_left == 0) tx_ready = 1'b1;
      end
      if (tx_wr_en === 1'b1) pend = 2;
    end else if (mode == 1) begin
      tx_ready = 1'b1;
    end else begin
      tx_ready = man_ready;
    end
    drive_req();
    #1;
    hs = rst_n ? (req_ready & req_valid) : '0;
  endtask

  task automatic wait_sent(input int n, input int budget);
    int b = 0;
    while (n_sent < n && b < budget) begin
      tick();
      b++;
    end
    check("wait_sent", n_sent >= n, 1);
  endtask

  task automatic wait_timeout(input int n, input int budget);
    int b = 0;
    while (n_timeout < n && b < budget) begin
      tick();
      b++;
    end
    check("wait_timeout", n_timeout >= n, 1);
  endtask

  task automatic wait_quiet(input int budget);
    int b = 0;
    while (b < budget && !(busy === 1'b0 && tx_ready === 1'b1 && pend == 0 && low_left == 0 && q_empty())) begin
      tick();
      b++;
    end
    check("quiet", b < budget, 1);
  endtask

  initial begin
    for (int k = 0; k < NUM_REQ; k++) begin
      rq_head[k] = 0;
      rq_tail[k] = 0;
    end
    hs        = '0;
    rst_n     = 1'b0;
    tx_ready  = 1'b1;
    req_valid = '0;
    req_data  = '0;
    req_last  = '0;

    // Reset state
    repeat (3) tick();
    check("rst_tx_data", tx_data, 8'h00);
    check("rst_wr_en", tx_wr_en, 0);
    check("rst_timeout", timeout, 0);
    check("rst_busy", busy, 0);
    check("rst_grant", grant, 4'b0000);
    check("rst_ready", req_ready, 4'b0000);
    rst_n = 1'b1;
    #1 hs = req_ready & req_valid;
    tick();
    check("idle_busy", busy, 0);

    // Reset priority: all four request at once
    base = n_sent;
    push(0, 1'b1, 8'h10);
    push(1, 1'b1, 8'h11);
    push(2, 1'b1, 8'h12);
    push(3, 1'b1, 8'h13);
    tick();
    check("rp_grant0", grant, 4'b0001);
    check("rp_ready0", req_ready, 4'b0001);
    wait_sent(base + 4, 200);
    check("rp_byte0", sent[base],   8'h10);
    check("rp_byte1", sent[base+1], 8'h11);
    check("rp_byte2", sent[base+2], 8'h12);
    check("rp_byte3", sent[base+3], 8'h13);
    check("rp_gnt0", sent_grant[base],   4'b0001);
    check("rp_gnt1", sent_grant[base+1], 4'b0010);
    check("rp_gnt2", sent_grant[base+2], 4'b0100);
    check("rp_gnt3", sent_grant[base+3], 4'b1000);
    wait_quiet(200);
    check("rp_count", n_sent - base, 4);

    // Message lock: requester 2 holds the grant across three bytes
    push(1, 1'b1, 8'h21);
    wait_sent(base + 5, 100);
    wait_quiet(200);
    base = n_sent;
    push(2, 1'b0, 8'h41);
    push(2, 1'b0, 8'h42);
    push(2, 1'b1, 8'h43);
    push(0, 1'b1, 8'h01);
    tick();
    check("ml_grant_first", grant, 4'b0100);
    wait_sent(base + 4, 300);
    check("ml_byte0", sent[base],   8'h41);
    check("ml_byte1", sent[base+1], 8'h42);
    check("ml_byte2", sent[base+2], 8'h43);
    check("ml_byte3", sent[base+3], 8'h01);
    check("ml_gnt1", sent_grant[base+1], 4'b0100);
    check("ml_gnt3", sent_grant[base+3], 4'b0001);
    wait_quiet(200);

    // Ack timeout: transceiver never leaves idle
    mode  = 1;
    base  = n_sent;
    tbase = n_timeout;
    push(1, 1'b1, 8'h55);
    wait_sent(base + 1, 100);
    check("to_byte", sent[base], 8'h55);
    check("to_gnt", sent_grant[base], 4'b0010);
    w = wr_cyc;
    wait_timeout(tbase + 1, 40);
    check("to_delay", to_cyc - w, ACK_TIMEOUT);
    check("to_busy", busy, 0);
    push(2, 1'b1, 8'h66);
    tick();
    check("to_width", timeout, 0);
    wait_sent(base + 2, 100);
    check("to_next_byte", sent[base+1], 8'h66);
    wait_timeout(tbase + 2, 40);
    mode = 0;
    wait_quiet(100);

    // Not ready: accept only once the transceiver is idle
    mode      = 2;
    man_ready = 1'b0;
    base      = n_sent;
    push(1, 1'b1, 8'h77);
    for (int i = 0; i < 5; i++) begin
      tick();
      check("nr_ready", req_ready, 4'b0000);
      check("nr_wr_en", tx_wr_en, 0);
    end
    check("nr_grant", grant, 4'b0010);
    man_ready = 1'b1;
    tick();
    check("nr_accept", req_ready, 4'b0010);
    mode = 0;
    tick();
    check("nr_wr", tx_wr_en, 1);
    check("nr_data", tx_data, 8'h77);
    wait_quiet(200);

    // Reset mid-operation while requester 3 holds the lock in S_DONE
    base = n_sent;
    push(3, 1'b0, 8'h81);
    push(3, 1'b1, 8'h82);
    wait_sent(base + 1, 100);
    repeat (4) tick();
    check("mr_busy", busy, 1);
    check("mr_grant_hold", grant, 4'b1000);
    check("mr_ready", req_ready, 4'b0000);
    push(0, 1'b1, 8'h03);
    tick();
    rst_n = 1'b0;
    #1;
    check("mr_tx_data", tx_data, 8'h00);
    check("mr_wr_en", tx_wr_en, 0);
    check("mr_timeout", timeout, 0);
    check("mr_busy_rst", busy, 0);
    check("mr_grant_rst", grant, 4'b0001);
    check("mr_ready_rst", req_ready, 4'b0000);
    tx_ready = 1'b1;
    pend     = 0;
    low_left = 0;
    #1;
    check("mr_ready_idle", req_ready, 4'b0001);
    tick();
    rst_n = 1'b1;
    #1 hs = req_ready & req_valid;
    wait_sent(base + 3, 150);
    check("mr_byte0", sent[base+1], 8'h03);
    check("mr_byte1", sent[base+2], 8'h82);
    check("mr_gnt0", sent_grant[base+1], 4'b0001);
    check("mr_gnt1", sent_grant[base+2], 4'b1000);
    wait_quiet(200);

    // Wrap-around: r_last is 3, requesters 0 and 3 compete
    base = n_sent;
    push(0, 1'b1, 8'h90);
    push(3, 1'b1, 8'h93);
    tick();
    check("wr_grant", grant, 4'b0001);
    check("wr_ready", req_ready, 4'b0001);
    wait_sent(base + 2, 150);
    check("wr_byte0", sent[base],   8'h90);
    check("wr_byte1", sent[base+1], 8'h93);
    check("wr_gnt1", sent_grant[base+1], 4'b1000);
    wait_quiet(200);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule

// File: doc/uart_tx_arbiter.md
# uart_tx_arbiter

Round-robin arbiter that shares the single transmit path of the UART transceiver among `NUM_REQ` byte requesters. It sits between the requesters and the transceiver's `i_Data_In`/`i_Wr_En`/`o_Tx_Ready` pins, and sequences exactly one byte per transceiver transmission. It supports multi-byte messages: a requester keeps the grant until it sends a byte flagged last. A busy-acknowledge timeout keeps the arbiter from stalling if the transceiver does not react to a write.

## Interface
- `NUM_REQ`, default 4: number of requesters, range 2..8.
- `ACK_TIMEOUT`, default 15: cycles to wait for `i_Tx_Ready` to drop after a write, range 1..255.

Ports:
- `i_Clk_12MHz`  in  1  sole clock, rising edge.
- `i_Reset_n`  in  1  asynchronous, active-low reset.
- `i_Req_Valid`  in  NUM_REQ  per-requester byte valid; bit k belongs to requester k.
- `i_Req_Data`  in  8*NUM_REQ  byte for requester k on bits [8k+7:8k]; stable while valid and not ready.
- `i_Req_Last`  in  NUM_REQ  qualifies the byte: 1 means last byte of the message.
- `o_Req_Ready`  out  NUM_REQ  one-hot accept; a transfer occurs on a cycle with valid & ready.
- `o_Grant`  out  NUM_REQ  one-hot current owner, or 0 when none.
- `o_Tx_Data`  out  8  byte to transceiver `i_Data_In`.
- `o_Tx_Wr_En`  out  1  one-cycle write strobe to transceiver `i_Wr_En`.
- `i_Tx_Ready`  in  1  transceiver `o_Tx_Ready`: 1 when the transmitter is idle.
- `o_Busy`  out  1  1 whenever the state is not S_IDLE or a message lock is held.
- `o_Timeout`  out  1  one-cycle pulse when the ack timeout expires.

## Operation
States:
- **S_IDLE**
  - Candidate: if the lock is held, the locked requester only.
  - Otherwise, the first requester with valid=1, scanning from `r_Last+1` modulo NUM_REQ and wrapping.
  - `o_Grant` = candidate (combinational), or 0 if there is none.
  - `o_Req_Ready[cand]` = valid[cand] & `i_Tx_Ready`; all other ready bits are 0.
- **Transfer** (in S_IDLE):
  - Register the data into `o_Tx_Data`, pulse `o_Tx_Wr_En` on the next cycle, clear the timeout counter, go to S_ACK.
  - If last=0: set the lock to the candidate.
  - If last=1: clear the lock and set `r_Last` to the candidate.
- **S_ACK**: wait for `i_Tx_Ready`=0, then go to S_DONE.
  - The counter increments every cycle in S_ACK.
  - If the counter reaches `ACK_TIMEOUT` with ready still 1: pulse `o_Timeout`, go to S_IDLE.
  - On timeout the byte is treated as consumed and the lock state is kept.
- **S_DONE**: wait for `i_Tx_Ready`=1, then go to S_IDLE.
- **Grant hold**: `o_Grant` keeps the owning requester through S_ACK and S_DONE.
- **Locked, owner not valid**: the arbiter stays in S_IDLE and other requesters are not granted. The lock persists until a byte with last=1 is sent.
- **Width rules**
  - Counter width is 8 bits and it saturates, no wrap.
  - `r_Last` width is clog2(NUM_REQ).
  - The round-robin scan wraps NUM_REQ-1 → 0.
- **Reset** (any time, including mid-message):
  - State S_IDLE, lock cleared, counter 0.
  - `r_Last` = NUM_REQ-1, so requester 0 has highest priority.
  - `o_Tx_Data`=0x00, `o_Tx_Wr_En`=0, `o_Timeout`=0, `o_Busy`=0.
  - `o_Grant` and `o_Req_Ready` reflect only the combinational S_IDLE logic.

## Timing
- Transfer accepted in cycle N; `o_Tx_Wr_En`=1 and `o_Tx_Data` valid in cycle N+1 only.
- The counter starts at cycle N+1.
- Next accept is possible no earlier than the cycle after `i_Tx_Ready` returns high in S_DONE.
- `o_Req_Ready` is never high outside S_IDLE and never high while `i_Tx_Ready`=0.
- Simultaneous requests: exactly one ready per cycle. The winner is the lowest index at or after `r_Last+1` (circular).
- A requester raising valid in the same cycle another message is released competes in the next S_IDLE cycle.
- `o_Timeout` is high for exactly one cycle, at the S_ACK→S_IDLE transition.
- `o_Busy` is registered (derived from next state / lock).

## Test plan
- **Reset priority**
  - Stimulus: after reset, valid=4'b1111, all last=1, data 0x10/0x11/0x12/0x13, transceiver model drops ready 2 cycles after the write and holds it low 20 cycles.
  - Required: bytes transmitted in order 0x10, 0x11, 0x12, 0x13; one Wr_En pulse each; grants 0001→0010→0100→1000.
- **Message lock**
  - Stimulus: requester 2 sends 0x41, 0x42, 0x43 with last=0,0,1 while requester 0 holds valid.
  - Required: 0x41, 0x42, 0x43 are sent contiguously, then requester 0's byte; `o_Grant`=0100 throughout the message.
- **Ack timeout**
  - Stimulus: transceiver ignores the write (ready stuck 1).
  - Required: `o_Timeout` pulses exactly ACK_TIMEOUT cycles after the Wr_En cycle; the arbiter returns to S_IDLE and accepts the next byte.
- **Not ready**
  - Stimulus: `i_Tx_Ready`=0 held with requester 1 valid.
  - Required: no ready and no Wr_En; the accept happens on the first cycle ready=1.
- **Reset mid-operation**
  - Stimulus: assert `i_Reset_n`=0 during S_DONE with the lock held by requester 3.
  - Required: all outputs at reset values immediately (asynchronously); after release, requester 0 wins over requester 3.
- **Wrap-around fairness**
  - Stimulus: `r_Last`=3, valid=4'b1001.
  - Required: requester 0 is granted first, then requester 3.
